// File: rtl/apb_adv_timer_cfg_seq.sv
// APB master that programs or stops one channel of the advanced timer by issuing
// a fixed register-write sequence. It reports done, or an error for PSLVERR or a wait-state timeout.
module apb_adv_timer_cfg_seq #(
    parameter int unsigned       APB_AW    = 12,
    parameter logic [APB_AW-1:0] BASE_ADDR = '0,
    parameter int unsigned       TIMEOUT   = 16
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              req_i,
    input  logic              op_i,
    input  logic [1:0]        ch_i,
    input  logic [31:0]       config_i,
    input  logic [31:0]       threshold_i,
    input  logic [31:0]       th_ch0_i,
    output logic              ack_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [1:0]        err_code_o,
    output logic [APB_AW-1:0] PADDR,
    output logic [31:0]       PWDATA,
    output logic              PWRITE,
    output logic              PSEL,
    output logic              PENABLE,
    input  logic [31:0]       PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StSetup, StAccess, StDone, StErr} state_e;

    state_e            state_q;
    logic [2:0]        step_q;
    logic [TW-1:0]     tcnt_q;
    logic              op_q;
    logic [1:0]        ch_q;
    logic [31:0]       cfg_q;
    logic [31:0]       thr_q;
    logic [31:0]       th0_q;
    logic              psel_q;
    logic              penable_q;
    logic [APB_AW-1:0] paddr_q;
    logic [31:0]       pwdata_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [1:0]        err_code_q;
    logic              last_step;
    logic              unused_prdata;

    // Program steps: CMD, CONFIG, THRESHOLD, TH_CH0, CMD, CMD. Stop is a single CMD write.
    function automatic logic [APB_AW-1:0] step_addr(input logic [1:0] ch, input logic op,
                                                    input logic [2:0] step);
        logic [7:0] off;
        off = 8'h00;
        if (!op) begin
            case (step)
                3'd1:    off = 8'h04;
                3'd2:    off = 8'h08;
                3'd3:    off = 8'h0C;
                default: off = 8'h00;
            endcase
        end
        return BASE_ADDR + APB_AW'({ch, 6'b0} + off);
    endfunction

    function automatic logic [31:0] step_data(input logic op, input logic [2:0] step,
                                              input logic [31:0] cfg, input logic [31:0] thr,
                                              input logic [31:0] th0);
        logic [31:0] d;
        if (op) begin
            d = 32'h0000_0002;
        end else begin
            case (step)
                3'd0:    d = 32'h0000_0008;
                3'd1:    d = cfg;
                3'd2:    d = thr;
                3'd3:    d = th0;
                3'd4:    d = 32'h0000_0004;
                default: d = 32'h0000_0001;
            endcase
        end
        return d;
    endfunction

    assign last_step     = op_q || (step_q == 3'd5);
    assign unused_prdata = ^PRDATA;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= StIdle;
            step_q     <= '0;
            tcnt_q     <= '0;
            op_q       <= 1'b0;
            ch_q       <= '0;
            cfg_q      <= '0;
            thr_q      <= '0;
            th0_q      <= '0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_i) begin
                        op_q       <= op_i;
                        ch_q       <= ch_i;
                        cfg_q      <= config_i;
                        thr_q      <= threshold_i;
                        th0_q      <= th_ch0_i;
                        step_q     <= '0;
                        tcnt_q     <= '0;
                        err_code_q <= '0;
                        paddr_q    <= step_addr(ch_i, op_i, 3'd0);
                        pwdata_q   <= step_data(op_i, 3'd0, config_i, threshold_i, th_ch0_i);
                        psel_q     <= 1'b1;
                        penable_q  <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= StSetup;
                    end
                end
                StSetup: begin
                    tcnt_q    <= '0;
                    penable_q <= 1'b1;
                    state_q   <= StAccess;
                end
                StAccess: begin
                    if (PREADY) begin
                        if (PSLVERR) begin
                            err_q      <= 1'b1;
                            err_code_q <= 2'b01;
                            psel_q     <= 1'b0;
                            penable_q  <= 1'b0;
                            busy_q     <= 1'b0;
                            state_q    <= StErr;
                        end else if (last_step) begin
                            done_q    <= 1'b1;
                            psel_q    <= 1'b0;
                            penable_q <= 1'b0;
                            busy_q    <= 1'b0;
                            state_q   <= StDone;
                        end else begin
                            // Next transfer starts immediately, no idle cycle in between.
                            step_q    <= step_q + 3'd1;
                            paddr_q   <= step_addr(ch_q, op_q, step_q + 3'd1);
                            pwdata_q  <= step_data(op_q, step_q + 3'd1, cfg_q, thr_q, th0_q);
                            penable_q <= 1'b0;
                            state_q   <= StSetup;
                        end
                    end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                        err_q      <= 1'b1;
                        err_code_q <= 2'b10;
                        psel_q     <= 1'b0;
                        penable_q  <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= StErr;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                StDone, StErr: state_q <= StIdle;
                default:       state_q <= StIdle;
            endcase
        end
    end

    assign ack_o      = (state_q == StIdle) && req_i && !HRESET;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign err_code_o = err_code_q;
    assign PADDR      = paddr_q;
    assign PWDATA     = pwdata_q;
    assign PWRITE     = psel_q;
    assign PSEL       = psel_q;
    assign PENABLE    = penable_q;

endmodule

// File: tb/tb_apb_adv_timer_cfg_seq.sv
// Bench for apb_adv_timer_cfg_seq: an APB slave model with configurable stalls/errors
// feeds captured writes back for comparison with a write list built from the register map.
module tb_apb_adv_timer_cfg_seq;

    localparam int TIMEOUT = 16;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        req_i, op_i;
    logic [1:0]  ch_i;
    logic [31:0] config_i, threshold_i, th_ch0_i;
    logic        ack_o, busy_o, done_o, err_o;
    logic [1:0]  err_code_o;
    logic [11:0] PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;

    int checks = 0;
    int errors = 0;

    // Slave model controls: indices are 0-based write numbers, -1 disables.
    int wr_idx = 0, acc_cnt = 0;
    int stall_idx = -1, stall_n = 0, err_idx = -1, hang_idx = -1;
    int stab_viol = 0, pwrite_viol = 0;
    logic [11:0] setup_addr;
    logic [31:0] setup_data;
    logic [11:0] cap_addr[$];
    logic [31:0] cap_data[$];
    logic [11:0] exp_addr[$];
    logic [31:0] exp_data[$];

    always #5 HCLK = ~HCLK;

    apb_adv_timer_cfg_seq #(
        .APB_AW   (12),
        .BASE_ADDR(12'h000),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .req_i      (req_i),
        .op_i       (op_i),
        .ch_i       (ch_i),
        .config_i   (config_i),
        .threshold_i(threshold_i),
        .th_ch0_i   (th_ch0_i),
        .ack_o      (ack_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .err_code_o (err_code_o),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PWRITE     (PWRITE),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    always @(negedge HCLK) begin
        logic rdy;
        if (PSEL && !PENABLE) begin
            setup_addr = PADDR;
            setup_data = PWDATA;
        end
        if (PSEL && !PWRITE) pwrite_viol++;
        if (PSEL && PENABLE) begin
            if (PADDR !== setup_addr || PWDATA !== setup_data) stab_viol++;
            if (wr_idx == hang_idx) rdy = 1'b0;
            else if (wr_idx == stall_idx && acc_cnt < stall_n) rdy = 1'b0;
            else rdy = 1'b1;
            PREADY  = rdy;
            PSLVERR = rdy && (wr_idx == err_idx);
            if (rdy) begin
                cap_addr.push_back(PADDR);
                cap_data.push_back(PWDATA);
                wr_idx++;
                acc_cnt = 0;
            end else begin
                acc_cnt++;
            end
        end else begin
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
        end
    end

    // Reference write list from the register map: channel base = ch*0x40.
    task automatic build_expected(input logic op, input logic [1:0] ch, input logic [31:0] cfg,
                                  input logic [31:0] thr, input logic [31:0] th0);
        int base;
        int offs[6] = '{0, 4, 8, 12, 0, 0};
        logic [31:0] vals[6];
        vals = '{32'h8, cfg, thr, th0, 32'h4, 32'h1};
        base = 64 * int'(ch);
        exp_addr.delete();
        exp_data.delete();
        if (op) begin
            exp_addr.push_back(12'(base));
            exp_data.push_back(32'h2);
        end else begin
            for (int i = 0; i < 6; i++) begin
                exp_addr.push_back(12'((base + offs[i]) % 4096));
                exp_data.push_back(vals[i]);
            end
        end
    endtask

    function automatic int writes_diff();
        int d = 0;
        if (cap_addr.size() != exp_addr.size()) d++;
        for (int i = 0; i < exp_addr.size() && i < cap_addr.size(); i++)
            if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) d++;
        return d;
    endfunction

    task automatic start_req(input logic op, input logic [1:0] ch, input logic [31:0] cfg,
                             input logic [31:0] thr, input logic [31:0] th0,
                             output logic ack_seen);
        @(negedge HCLK); #1;
        cap_addr.delete();
        cap_data.delete();
        wr_idx = 0; acc_cnt = 0; stab_viol = 0; pwrite_viol = 0;
        req_i = 1'b1; op_i = op; ch_i = ch;
        config_i = cfg; threshold_i = thr; th_ch0_i = th0;
        #1 ack_seen = ack_o;
        @(posedge HCLK); #1;
        req_i = 1'b0;
        op_i = 1'($urandom); ch_i = 2'($urandom);
        config_i = $urandom; threshold_i = $urandom; th_ch0_i = $urandom;
    endtask

    // Cycle 0 is the ack cycle; returns the cycle of done_o/err_o, or -1 on budget expiry.
    task automatic wait_end(output int end_cyc, output logic d, output logic e,
                            output int psel_cyc, output int busy_cyc);
        end_cyc = -1; d = 1'b0; e = 1'b0; psel_cyc = 0; busy_cyc = 0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge HCLK); #1;
            if (PSEL) psel_cyc++;
            if (busy_o) busy_cyc++;
            if (done_o || err_o) begin
                end_cyc = c; d = done_o; e = err_o;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge HCLK); #1;
        req_i = 1'b1;
        #1;
        checks++;
        if ({ack_o, busy_o, done_o, err_o, err_code_o, PSEL, PENABLE, PWRITE} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 0", {ack_o, busy_o, done_o, err_o,
                     err_code_o, PSEL, PENABLE, PWRITE});
        end
        checks++;
        if (PADDR !== 12'h0 || PWDATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: got %h/%h want 0/0", PADDR, PWDATA);
        end
        req_i = 1'b0;
        HRESET = 1'b0;
        @(negedge HCLK); #1;
        checks++;
        if ({busy_o, PSEL, done_o, err_o} !== 4'b0) begin
            errors++;
            $display("FAIL reset_idle: got %b want 0", {busy_o, PSEL, done_o, err_o});
        end
    endtask

    task automatic test_program();
        logic ack; logic d, e; int endc, pc, bc;
        build_expected(1'b0, 2'd2, 32'h0000_0A01, 32'h0100_0000, 32'h0003_0080);
        start_req(1'b0, 2'd2, 32'h0000_0A01, 32'h0100_0000, 32'h0003_0080, ack);
        checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL prog_ack: got %b want 1", ack); end
        wait_end(endc, d, e, pc, bc);
        checks++;
        if (endc !== 13 || d !== 1'b1 || e !== 1'b0) begin
            errors++;
            $display("FAIL prog_latency: got cyc %0d done %b err %b want 13 1 0", endc, d, e);
        end
        checks++;
        if (writes_diff() !== 0) begin
            errors++;
            $display("FAIL prog_writes: got %0d writes (%0d differ) want %0d", cap_addr.size(),
                     writes_diff(), exp_addr.size());
        end
        checks++;
        if (pc !== 12 || bc !== 12 || err_code_o !== 2'b00) begin
            errors++;
            $display("FAIL prog_busy: got psel %0d busy %0d code %b want 12 12 00", pc, bc,
                     err_code_o);
        end
        checks++;
        if (pwrite_viol !== 0 || stab_viol !== 0) begin
            errors++;
            $display("FAIL prog_protocol: got pwrite %0d stab %0d want 0 0", pwrite_viol,
                     stab_viol);
        end
    endtask

    task automatic test_stop();
        logic ack; logic d, e; int endc, pc, bc;
        build_expected(1'b1, 2'd3, 32'h0, 32'h0, 32'h0);
        start_req(1'b1, 2'd3, $urandom, $urandom, $urandom, ack);
        wait_end(endc, d, e, pc, bc);
        checks++;
        if (ack !== 1'b1 || endc !== 3 || d !== 1'b1 || e !== 1'b0) begin
            errors++;
            $display("FAIL stop_latency: got ack %b cyc %0d done %b err %b want 1 3 1 0", ack,
                     endc, d, e);
        end
        checks++;
        if (writes_diff() !== 0 || cap_addr.size() != 1) begin
            errors++;
            $display("FAIL stop_writes: got %0d writes first %h want 1 write 0c0/2",
                     cap_addr.size(), cap_addr.size() > 0 ? cap_addr[0] : 12'hfff);
        end
    endtask

    task automatic test_stall();
        logic ack; logic d, e; int endc, pc, bc;
        logic [31:0] cfg, thr, th0;
        cfg = $urandom; thr = $urandom; th0 = $urandom;
        build_expected(1'b0, 2'd0, cfg, thr, th0);
        stall_idx = 1; stall_n = 3;
        start_req(1'b0, 2'd0, cfg, thr, th0, ack);
        wait_end(endc, d, e, pc, bc);
        stall_idx = -1; stall_n = 0;
        checks++;
        if (endc !== 16 || d !== 1'b1) begin
            errors++;
            $display("FAIL stall_latency: got cyc %0d done %b want 16 1", endc, d);
        end
        checks++;
        if (writes_diff() !== 0 || stab_viol !== 0) begin
            errors++;
            $display("FAIL stall_writes: got %0d differ %0d unstable want 0 0", writes_diff(),
                     stab_viol);
        end
    endtask

    task automatic test_slverr();
        logic ack; logic d, e; int endc, pc, bc, late_psel;
        logic [31:0] cfg, thr, th0;
        cfg = $urandom; thr = $urandom; th0 = $urandom;
        build_expected(1'b0, 2'd1, cfg, thr, th0);
        while (exp_addr.size() > 3) begin
            void'(exp_addr.pop_back());
            void'(exp_data.pop_back());
        end
        err_idx = 2;
        start_req(1'b0, 2'd1, cfg, thr, th0, ack);
        wait_end(endc, d, e, pc, bc);
        err_idx = -1;
        checks++;
        if (endc !== 7 || e !== 1'b1 || d !== 1'b0 || err_code_o !== 2'b01) begin
            errors++;
            $display("FAIL slverr_end: got cyc %0d err %b done %b code %b want 7 1 0 01", endc,
                     e, d, err_code_o);
        end
        late_psel = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge HCLK); #1;
            if (PSEL || busy_o || err_o) late_psel++;
        end
        checks++;
        if (late_psel !== 0 || err_code_o !== 2'b01 || writes_diff() !== 0) begin
            errors++;
            $display("FAIL slverr_after: got activity %0d code %b differ %0d want 0 01 0",
                     late_psel, err_code_o, writes_diff());
        end
    endtask

    task automatic test_timeout();
        logic ack; logic d, e; int endc, pc, bc;
        hang_idx = 0;
        start_req(1'b0, 2'($urandom), $urandom, $urandom, $urandom, ack);
        wait_end(endc, d, e, pc, bc);
        hang_idx = -1;
        checks++;
        if (endc !== 2 + TIMEOUT || e !== 1'b1 || err_code_o !== 2'b10) begin
            errors++;
            $display("FAIL timeout_end: got cyc %0d err %b code %b want %0d 1 10", endc, e,
                     err_code_o, 2 + TIMEOUT);
        end
        checks++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0 || busy_o !== 1'b0 || cap_addr.size() != 0) begin
            errors++;
            $display("FAIL timeout_bus: got psel %b pen %b busy %b writes %0d want 0 0 0 0",
                     PSEL, PENABLE, busy_o, cap_addr.size());
        end
    endtask

    task automatic test_back_to_back();
        logic ack; logic d, e; int endc, pc, bc;
        build_expected(1'b1, 2'd2, 32'h0, 32'h0, 32'h0);
        start_req(1'b1, 2'd2, $urandom, $urandom, $urandom, ack);
        checks++;
        if (err_code_o !== 2'b00) begin
            errors++;
            $display("FAIL b2b_code_clear: got %b want 00", err_code_o);
        end
        wait_end(endc, d, e, pc, bc);
        // Request raised during the DONE cycle must wait for the IDLE cycle.
        req_i = 1'b1; op_i = 1'b1; ch_i = 2'd1;
        #1;
        checks++;
        if (ack_o !== 1'b0 || d !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done_ack: got ack %b done %b want 0 1", ack_o, d);
        end
        build_expected(1'b1, 2'd1, 32'h0, 32'h0, 32'h0);
        @(negedge HCLK); #1;
        cap_addr.delete(); cap_data.delete(); wr_idx = 0; acc_cnt = 0;
        ack = ack_o;
        @(posedge HCLK); #1;
        req_i = 1'b0;
        wait_end(endc, d, e, pc, bc);
        checks++;
        if (ack !== 1'b1 || endc !== 3 || d !== 1'b1 || writes_diff() !== 0) begin
            errors++;
            $display("FAIL b2b_second: got ack %b cyc %0d done %b differ %0d want 1 3 1 0", ack,
                     endc, d, writes_diff());
        end
    endtask

    task automatic test_reset_mid();
        logic ack; logic d, e; int endc, pc, bc, quiet;
        logic [31:0] cfg, thr, th0;
        bit found = 1'b0;
        hang_idx = 3;
        start_req(1'b0, 2'd1, $urandom, $urandom, $urandom, ack);
        for (int i = 0; i < 40; i++) begin
            @(negedge HCLK); #1;
            if (PSEL && PENABLE && wr_idx == 3) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL rst_mid_reach: got none want write 4"); end
        HRESET = 1'b1;
        @(negedge HCLK); #1;
        HRESET = 1'b0;
        hang_idx = -1;
        checks++;
        if ({PSEL, PENABLE, busy_o, done_o, err_o} !== 5'b0) begin
            errors++;
            $display("FAIL rst_mid_drop: got %b want 00000", {PSEL, PENABLE, busy_o, done_o,
                     err_o});
        end
        quiet = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge HCLK); #1;
            if (done_o || err_o || PSEL) quiet++;
        end
        checks++;
        if (quiet !== 0) begin
            errors++;
            $display("FAIL rst_mid_quiet: got %0d active cycles want 0", quiet);
        end
        cfg = $urandom; thr = $urandom; th0 = $urandom;
        build_expected(1'b0, 2'd3, cfg, thr, th0);
        start_req(1'b0, 2'd3, cfg, thr, th0, ack);
        wait_end(endc, d, e, pc, bc);
        checks++;
        if (endc !== 13 || d !== 1'b1 || writes_diff() !== 0) begin
            errors++;
            $display("FAIL rst_mid_restart: got cyc %0d done %b differ %0d want 13 1 0", endc, d,
                     writes_diff());
        end
    endtask

    task automatic test_random();
        logic ack; logic d, e; int endc, pc, bc, n, want;
        logic op; logic [1:0] ch; logic [31:0] cfg, thr, th0;
        for (int it = 0; it < 20; it++) begin
            op = 1'($urandom); ch = 2'($urandom);
            cfg = $urandom; thr = $urandom; th0 = $urandom;
            build_expected(op, ch, cfg, thr, th0);
            n = exp_addr.size();
            stall_idx = $urandom_range(0, n - 1);
            stall_n = $urandom_range(0, 4);
            want = 2 * n + stall_n + 1;
            start_req(op, ch, cfg, thr, th0, ack);
            wait_end(endc, d, e, pc, bc);
            checks++;
            if (ack !== 1'b1 || endc !== want || d !== 1'b1 || e !== 1'b0 || bc !== want - 1) begin
                errors++;
                $display("FAIL rand_timing[%0d]: got ack %b cyc %0d done %b busy %0d want 1 %0d 1 %0d",
                         it, ack, endc, d, bc, want, want - 1);
            end
            checks++;
            if (writes_diff() !== 0 || stab_viol !== 0) begin
                errors++;
                $display("FAIL rand_writes[%0d]: got %0d differ %0d unstable want 0 0", it,
                         writes_diff(), stab_viol);
            end
        end
        stall_idx = -1; stall_n = 0;
    endtask

    initial begin
        HRESET = 1'b1;
        req_i = 1'b0; op_i = 1'b0; ch_i = 2'd0;
        config_i = '0; threshold_i = '0; th_ch0_i = '0; PRDATA = '0;
        repeat (3) @(posedge HCLK);
        test_reset();
        test_program();
        test_stop();
        test_stall();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
